// File: rtl/change_dispenser.sv
// Coin-return unit: pays a dollar amount out as 10/5/1 coins, largest first,
// through a valid/ack hopper handshake while tracking per-hopper inventory.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a change request
// SELECT | pick the largest coin that fits the remainder and is in stock
// EJECT  | coin requested from hopper, waiting for eject_ack
// DONE   | one-cycle completion pulse, short/short_amount valid
module change_dispenser #(
   parameter int               AMT_W    = 8,
   parameter int               CNT_W    = 8,
   parameter logic [CNT_W-1:0] INIT_CNT = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [AMT_W-1:0] req_amount,
   output logic             eject_valid,
   output logic [1:0]       eject_coin,
   input  logic             eject_ack,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] short_amount,
   output logic             busy,
   input  logic             restock,
   input  logic [1:0]       restock_sel,
   input  logic [CNT_W-1:0] restock_qty,
   output logic [CNT_W-1:0] cnt_10,
   output logic [CNT_W-1:0] cnt_5,
   output logic [CNT_W-1:0] cnt_1
);

   localparam logic [1:0] COIN_NONE = 2'd0;
   localparam logic [1:0] COIN_10   = 2'd1;
   localparam logic [1:0] COIN_5    = 2'd2;
   localparam logic [1:0] COIN_1    = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      EJECT  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state, state_next;
   logic [AMT_W-1:0] remaining, remaining_next;
   logic [1:0]       coin_next;
   logic             short_next;
   logic [AMT_W-1:0] short_amount_next;
   logic             ack_take;

   function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] code);
      logic [AMT_W-1:0] val;
      case (code)
         COIN_10: val = AMT_W'(10);
         COIN_5:  val = AMT_W'(5);
         COIN_1:  val = AMT_W'(1);
         default: val = '0;
      endcase
      return val;
   endfunction

   // Add restock and subtract an ack in one step so a same-edge pair nets out
   // before saturation; a decrement never hits an empty hopper.
   function automatic logic [CNT_W-1:0] next_count(
      input logic [CNT_W-1:0] cur,
      input logic             add_en,
      input logic [CNT_W-1:0] qty,
      input logic             dec
   );
      logic [CNT_W:0] sum;
      sum = {1'b0, cur} + (add_en ? {1'b0, qty} : {(CNT_W+1){1'b0}})
            - {{CNT_W{1'b0}}, dec};
      if (sum[CNT_W])
         return '1;
      return sum[CNT_W-1:0];
   endfunction

   assign req_ready   = (state == IDLE);
   assign busy        = (state != IDLE);
   assign eject_valid = (state == EJECT);
   assign done        = (state == DONE);
   assign ack_take    = (state == EJECT) && eject_ack;

   always_comb begin
      state_next        = state;
      remaining_next    = remaining;
      coin_next         = eject_coin;
      short_next        = short;
      short_amount_next = short_amount;
      case (state)
         IDLE: begin
            if (req_valid) begin
               remaining_next    = req_amount;
               short_next        = 1'b0;
               short_amount_next = '0;
               state_next        = (req_amount == '0) ? DONE : SELECT;
            end
         end
         SELECT: begin
            if ((remaining >= coin_value(COIN_10)) && (cnt_10 != '0)) begin
               coin_next  = COIN_10;
               state_next = EJECT;
            end else if ((remaining >= coin_value(COIN_5)) && (cnt_5 != '0)) begin
               coin_next  = COIN_5;
               state_next = EJECT;
            end else if ((remaining >= coin_value(COIN_1)) && (cnt_1 != '0)) begin
               coin_next  = COIN_1;
               state_next = EJECT;
            end else begin
               short_next        = 1'b1;
               short_amount_next = remaining;
               state_next        = DONE;
            end
         end
         EJECT: begin
            if (eject_ack) begin
               remaining_next = remaining - coin_value(eject_coin);
               coin_next      = COIN_NONE;
               state_next     = (remaining_next == '0) ? DONE : SELECT;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         remaining    <= '0;
         eject_coin   <= COIN_NONE;
         short        <= 1'b0;
         short_amount <= '0;
      end else begin
         state        <= state_next;
         remaining    <= remaining_next;
         eject_coin   <= coin_next;
         short        <= short_next;
         short_amount <= short_amount_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_10 <= INIT_CNT;
         cnt_5  <= INIT_CNT;
         cnt_1  <= INIT_CNT;
      end else begin
         cnt_10 <= next_count(cnt_10, restock && (restock_sel == COIN_10), restock_qty,
                              ack_take && (eject_coin == COIN_10));
         cnt_5  <= next_count(cnt_5, restock && (restock_sel == COIN_5), restock_qty,
                              ack_take && (eject_coin == COIN_5));
         cnt_1  <= next_count(cnt_1, restock && (restock_sel == COIN_1), restock_qty,
                              ack_take && (eject_coin == COIN_1));
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a small payout model pushes the
// expected coin sequence per request; the hopper side pops and compares.
module tb_change_dispenser;

   localparam int AMT_W   = 8;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [AMT_W-1:0] req_amount = '0;
   logic             eject_valid;
   logic [1:0]       eject_coin;
   logic             eject_ack = 1'b0;
   logic             done;
   logic             short;
   logic [AMT_W-1:0] short_amount;
   logic             busy;
   logic             restock = 1'b0;
   logic [1:0]       restock_sel = '0;
   logic [CNT_W-1:0] restock_qty = '0;
   logic [CNT_W-1:0] cnt_10, cnt_5, cnt_1;

   change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_CNT('0)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_amount(req_amount),
      .eject_valid(eject_valid), .eject_coin(eject_coin), .eject_ack(eject_ack),
      .done(done), .short(short), .short_amount(short_amount), .busy(busy),
      .restock(restock), .restock_sel(restock_sel), .restock_qty(restock_qty),
      .cnt_10(cnt_10), .cnt_5(cnt_5), .cnt_1(cnt_1)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int m_cnt[4];
   int exp_q[$];
   int exp_short, exp_sa;
   int ack_rs_sel = 0;
   int ack_rs_qty = 0;
   bit hold_req = 1'b0;

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   function automatic int den(input int k);
      case (k)
         1: return 10;
         2: return 5;
         3: return 1;
         default: return 0;
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_counts(input string tag);
      check_eq({tag, "_cnt10"}, cnt_10, m_cnt[1]);
      check_eq({tag, "_cnt5"}, cnt_5, m_cnt[2]);
      check_eq({tag, "_cnt1"}, cnt_1, m_cnt[3]);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req_valid = 1'b0;
      eject_ack = 1'b0;
      restock = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      m_cnt = '{default: 0};
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic do_restock(input int sel, input int qty);
      restock = 1'b1;
      restock_sel = 2'(sel);
      restock_qty = CNT_W'(qty);
      @(negedge clk);
      restock = 1'b0;
      if (sel != 0) m_cnt[sel] = sat(m_cnt[sel] + qty);
   endtask

   task automatic run_request(input int amt, input int ack_delay);
      int rem, c[4], cyc, exp_coin;
      bit found, first, got_done;
      c = m_cnt;
      rem = amt;
      found = 1'b1;
      while (rem != 0 && found) begin
         found = 1'b0;
         for (int k = 1; k <= 3; k++) begin
            if (!found && rem >= den(k) && c[k] > 0) begin
               exp_q.push_back(k);
               rem -= den(k);
               c[k]--;
               found = 1'b1;
            end
         end
      end
      exp_short = (rem != 0) ? 1 : 0;
      exp_sa = rem;

      check_eq("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_amount = AMT_W'(amt);
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      first = 1'b1;
      got_done = 1'b0;
      while (cyc < 300 && !got_done) begin
         if (done) begin
            got_done = 1'b1;
            if (amt == 0) begin
               check_eq("zero_done_lat", cyc, 1);
               check_eq("zero_busy", busy, 1);
            end
            check_eq("coins_left", exp_q.size(), 0);
            check_eq("short", short, exp_short);
            check_eq("short_amount", short_amount, exp_sa);
            check_counts("done");
            @(negedge clk);
            check_eq("done_pulse", done, 0);
            check_eq("busy_after", busy, 0);
            check_eq("short_held", short, exp_short);
            check_eq("short_amount_held", short_amount, exp_sa);
         end else if (eject_valid) begin
            if (first) begin
               check_eq("first_eject_lat", cyc, 2);
               first = 1'b0;
            end
            if (exp_q.size() == 0) begin
               check_eq("unexpected_coin_qsize", exp_q.size(), 1);
               exp_coin = 0;
            end else begin
               exp_coin = exp_q.pop_front();
            end
            check_eq("eject_coin", eject_coin, exp_coin);
            for (int i = 0; i < ack_delay; i++) begin
               if (hold_req) begin
                  req_valid = 1'b1;
                  req_amount = AMT_W'(99);
               end
               @(negedge clk);
               cyc++;
               check_eq("hold_valid", eject_valid, 1);
               check_eq("hold_coin", eject_coin, exp_coin);
               check_eq("hold_ready", req_ready, 0);
               check_counts("hold");
            end
            req_valid = 1'b0;
            eject_ack = 1'b1;
            if (ack_rs_sel != 0) begin
               restock = 1'b1;
               restock_sel = 2'(ack_rs_sel);
               restock_qty = CNT_W'(ack_rs_qty);
            end
            @(negedge clk);
            cyc++;
            eject_ack = 1'b0;
            restock = 1'b0;
            if (exp_coin != 0) m_cnt[exp_coin]--;
            if (ack_rs_sel != 0) m_cnt[ack_rs_sel] = sat(m_cnt[ack_rs_sel] + ack_rs_qty);
            ack_rs_sel = 0;
            check_eq("eject_valid_drop", eject_valid, 0);
            check_eq("eject_coin_clear", eject_coin, 0);
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!got_done) check_eq("timeout_done", got_done, 1);
   endtask

   initial begin
      int w;
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst_req_ready", req_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_eject_valid", eject_valid, 0);
      check_eq("rst_eject_coin", eject_coin, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_short", short, 0);
      check_eq("rst_short_amount", short_amount, 0);
      do_reset();
      check_counts("rst");

      // 27 with 10x3, 5x3, 1x5 -> 10,10,5,1,1
      do_restock(1, 3);
      do_restock(2, 3);
      do_restock(3, 5);
      run_request(27, 0);
      check_eq("t1_cnt10", cnt_10, 1);
      check_eq("t1_cnt5", cnt_5, 2);
      check_eq("t1_cnt1", cnt_1, 3);

      run_request(0, 0);

      // 13 with 10x0, 5x1, 1x2 -> 5,1,1 then short 6
      do_reset();
      do_restock(2, 1);
      do_restock(3, 2);
      run_request(13, 0);
      check_eq("t3_short", short, 1);
      check_eq("t3_short_amount", short_amount, 6);

      // stalled ack with a request knocking while busy
      do_reset();
      do_restock(1, 20);
      do_restock(2, 20);
      do_restock(3, 20);
      hold_req = 1'b1;
      run_request(15, 4);
      hold_req = 1'b0;
      check_eq("t4_idle_after", busy, 0);
      run_request(7, 1);

      // restock coinciding with a 10 ack, then saturation
      do_reset();
      do_restock(1, 2);
      ack_rs_sel = 1;
      ack_rs_qty = 5;
      run_request(10, 0);
      check_eq("t5_cnt10", cnt_10, 6);
      do_restock(3, 250);
      do_restock(3, 10);
      check_eq("t5_cnt1_sat", cnt_1, 255);

      // asynchronous reset in the middle of an eject
      do_reset();
      do_restock(1, 3);
      req_valid = 1'b1;
      req_amount = AMT_W'(10);
      @(negedge clk);
      req_valid = 1'b0;
      w = 0;
      while (!eject_valid && w < 10) begin
         @(negedge clk);
         w++;
      end
      check_eq("t6_reached_eject", eject_valid, 1);
      #2 reset = 1'b0;
      #1;
      check_eq("t6_async_eject_valid", eject_valid, 0);
      check_eq("t6_async_busy", busy, 0);
      check_eq("t6_async_cnt10", cnt_10, 0);
      @(negedge clk);
      reset = 1'b1;
      m_cnt = '{default: 0};
      exp_q.delete();
      @(negedge clk);
      check_eq("t6_req_ready", req_ready, 1);
      check_eq("t6_short", short, 0);
      check_eq("t6_eject_coin", eject_coin, 0);
      check_counts("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
